// File: rtl/dmem_arbiter.sv
// dmem_arbiter: data-memory controller for the single-cycle RV32I core.
// Shares one single-port, synchronous-read memory between the core
// load/store path and a DMA/loader port. Handles byte/half/word lane steering,
// load extension and alignment faults. Guarantees DMA forward progress under
// continuous core traffic with a small starvation counter.
module dmem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [WIDTH-1:0]  core_wdata,
    input  logic [2:0]        core_funct3,
    output logic              core_stall,
    output logic              core_done,
    output logic [WIDTH-1:0]  core_rdata,
    output logic              core_fault,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [WIDTH-1:0]  dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [WIDTH-1:0]  dma_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_RD   = 2'd1,
        CORE_RESP = 2'd2,
        DMA_RD    = 2'd3
    } state_e;

    state_e           state_q,      state_d;
    logic [1:0]       starve_cnt_q, starve_cnt_d;
    logic [2:0]       ld_funct3_q,  ld_funct3_d;
    logic [1:0]       ld_off_q,     ld_off_d;
    logic             core_done_q,  core_done_d;
    logic             core_fault_q, core_fault_d;
    logic [WIDTH-1:0] core_rdata_q, core_rdata_d;
    logic             dma_rvalid_q, dma_rvalid_d;

    logic             core_req;
    logic             core_load;
    logic             core_store;
    logic             funct_ok;
    logic             align_ok;
    logic             core_bad;
    logic             dma_wins;
    logic             core_wins;
    logic [WIDTH-1:0] ld_lane;
    logic [WIDTH-1:0] ld_data;

    // DMA is always word-aligned; its two byte-offset bits carry no meaning.
    logic unused_dma_lsbs;
    assign unused_dma_lsbs = ^dma_addr[1:0];

    // Decode the core request: legal funct3 for the direction and natural alignment.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        funct_ok   = 1'b0;
        align_ok   = 1'b0;
        core_req   = core_rd_en | core_wr_en;
        core_load  = core_rd_en & ~core_wr_en;
        core_store = core_wr_en & ~core_rd_en;
        if (core_load) begin
            funct_ok = core_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (core_store) begin
            funct_ok = core_funct3 inside {3'b000, 3'b001, 3'b010};
        end
        case (core_funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~core_addr[0];
            2'b10:   align_ok = (core_addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        core_bad = ~(funct_ok & align_ok);
    end

    // Arbitration: core wins unless DMA has lost three contended rounds in a row.
    always_comb begin
        dma_wins  = dma_req & (~core_req | (starve_cnt_q == 2'd3));
        core_wins = core_req & ~dma_wins;
    end

    // Shift the addressed lane of the returned word down and extend it.
    always_comb begin
        ld_lane = mem_rdata >> {ld_off_q, 3'b000};
        case (ld_funct3_q)
            3'b000:  ld_data = {{(WIDTH-8){ld_lane[7]}},  ld_lane[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}},        ld_lane[7:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}},       ld_lane[15:0]};
            default: ld_data = ld_lane;
        endcase
    end

    // Next-state, memory strobe and response logic.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ld_funct3_d  = ld_funct3_q;
        ld_off_d     = ld_off_q;
        core_done_d  = 1'b0;
        core_fault_d = 1'b0;
        core_rdata_d = '0;
        dma_rvalid_d = 1'b0;
        dma_gnt      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 4'b0000;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (core_wins) begin
                    if (dma_req && starve_cnt_q != 2'd3) begin
                        starve_cnt_d = starve_cnt_q + 2'd1;
                    end
                    if (core_bad) begin
                        // Faulting accesses never touch memory.
                        state_d      = CORE_RESP;
                        core_done_d  = 1'b1;
                        core_fault_d = 1'b1;
                    end else if (core_load) begin
                        state_d     = CORE_RD;
                        mem_en      = 1'b1;
                        mem_addr    = core_addr[ADDR_W-1:2];
                        ld_funct3_d = core_funct3;
                        ld_off_d    = core_addr[1:0];
                    end else begin
                        state_d     = CORE_RESP;
                        core_done_d = 1'b1;
                        mem_en      = 1'b1;
                        mem_addr    = core_addr[ADDR_W-1:2];
                        case (core_funct3[1:0])
                            2'b00: begin
                                mem_we    = 4'b0001 << core_addr[1:0];
                                mem_wdata = {4{core_wdata[7:0]}};
                            end
                            2'b01: begin
                                mem_we    = core_addr[1] ? 4'b1100 : 4'b0011;
                                mem_wdata = {2{core_wdata[15:0]}};
                            end
                            default: begin
                                mem_we    = 4'b1111;
                                mem_wdata = core_wdata;
                            end
                        endcase
                    end
                end else if (dma_wins) begin
                    starve_cnt_d = 2'd0;
                    dma_gnt      = 1'b1;
                    mem_en       = 1'b1;
                    mem_addr     = dma_addr[ADDR_W-1:2];
                    if (dma_we) begin
                        mem_we    = 4'b1111;
                        mem_wdata = dma_wdata;
                    end else begin
                        state_d      = DMA_RD;
                        dma_rvalid_d = 1'b1;
                    end
                end
            end
            CORE_RD: begin
                state_d      = CORE_RESP;
                core_done_d  = 1'b1;
                core_rdata_d = ld_data;
            end
            CORE_RESP: state_d = IDLE;
            DMA_RD:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // The strobe and grant must drop in the very cycle reset is sampled.
        if (rst) begin
            dma_gnt   = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 4'b0000;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 2'd0;
            ld_funct3_q  <= 3'b000;
            ld_off_q     <= 2'b00;
            core_done_q  <= 1'b0;
            core_fault_q <= 1'b0;
            core_rdata_q <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_off_q     <= ld_off_d;
            core_done_q  <= core_done_d;
            core_fault_q <= core_fault_d;
            core_rdata_q <= core_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign core_done  = core_done_q;
    assign core_fault = core_fault_q;
    assign core_rdata = core_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    // Read data comes straight from the memory in the cycle it is valid.
    assign dma_rdata  = dma_rvalid_q ? mem_rdata : '0;
    assign core_stall = core_req & ~core_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed and random core/DMA traffic
// against a byte-addressed reference memory and rule-based expectations.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        core_rd_en;
    logic        core_wr_en;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic        core_stall;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_fault;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory attached to the DUT, with a preload port used during reset.
    logic [31:0] ram [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    // Reference model: plain byte-addressed memory.
    logic [7:0]  ref_mem [0:1023];

    dmem_arbiter #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3), .core_stall(core_stall),
        .core_done(core_done), .core_rdata(core_rdata), .core_fault(core_fault),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memory.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_val;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (rd && wr) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int          size;
        logic [31:0] v;
        logic [31:0] mask;
        size = 1 << f3[1:0];
        v = 0;
        for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h0000_03FC;
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    // One core access: check the issue-cycle strobe, then latency, stall and response.
    task automatic core_access(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input string tag, output logic [31:0] obs);
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        int          lat, size, cycles, stalls;
        exp_fault = ref_fault(rd, wr, f3, addr);
        exp_rd    = (exp_fault || wr) ? 32'd0 : ref_load(f3, addr);
        lat       = (rd && !wr && !exp_fault) ? 2 : 1;
        size      = 1 << f3[1:0];
        exp_we    = 4'b0000;
        for (int k = 0; k < size; k++) exp_we = exp_we | 4'(1 << (int'(addr[1:0]) + k));
        exp_wd = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                 (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;

        @(posedge clk); #1;
        core_rd_en = rd; core_wr_en = wr; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        @(negedge clk);
        check({tag, ".mem_en"}, 32'(mem_en), 32'(!exp_fault));
        if (!exp_fault) begin
            check({tag, ".mem_addr"}, 32'(mem_addr), addr >> 2);
            if (wr) begin
                check({tag, ".mem_we"}, 32'(mem_we), 32'(exp_we));
                check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
                for (int k = 0; k < size; k++) ref_mem[addr + k] = wd[8*k +: 8];
            end else begin
                check({tag, ".mem_we_rd"}, 32'(mem_we), 32'd0);
            end
        end
        cycles = 0; stalls = 0;
        while (!core_done && cycles < 8) begin
            if (core_stall) stalls++;
            @(negedge clk);
            cycles++;
        end
        check({tag, ".latency"}, 32'(cycles), 32'(lat));
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat));
        check({tag, ".fault"}, 32'(core_fault), 32'(exp_fault));
        if (rd || exp_fault) check({tag, ".rdata"}, core_rdata, exp_rd);
        obs = core_rdata;
        @(posedge clk); #1;
        core_rd_en = 1'b0; core_wr_en = 1'b0;
    endtask

    // One uncontended DMA access.
    task automatic dma_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input string tag);
        int          cycles;
        logic [31:0] exp;
        exp = ref_word(a);
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        @(negedge clk);
        cycles = 0;
        while (!dma_gnt && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ".gnt"}, 32'(dma_gnt), 32'd1);
        check({tag, ".mem_en"}, 32'(mem_en), 32'd1);
        check({tag, ".mem_addr"}, 32'(mem_addr), a >> 2);
        check({tag, ".mem_we"}, 32'(mem_we), we ? 32'hF : 32'h0);
        if (we) begin
            check({tag, ".mem_wdata"}, mem_wdata, wd);
            for (int k = 0; k < 4; k++) ref_mem[(a & 32'h3FC) + k] = wd[8*k +: 8];
        end
        @(posedge clk); #1;
        dma_req = 1'b0;
        @(negedge clk);
        check({tag, ".rvalid"}, 32'(dma_rvalid), 32'(!we));
        if (!we) check({tag, ".rdata"}, dma_rdata, exp);
    endtask

    // Continuous core loads against a held DMA read: DMA wins the 4th contended round.
    task automatic starve_run(input logic [31:0] caddr, input logic [31:0] daddr,
                              input string tag);
        int          core_issues, cycles;
        logic        got;
        logic [31:0] exp_core, exp_dma;
        exp_core = ref_word(caddr);
        exp_dma  = ref_word(daddr);
        core_issues = 0; cycles = 0; got = 1'b0;
        @(posedge clk); #1;
        core_rd_en = 1'b1; core_wr_en = 1'b0; core_funct3 = 3'b010; core_addr = caddr;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = daddr;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (core_done) check({tag, ".core_rdata"}, core_rdata, exp_core);
            if (dma_gnt) got = 1'b1;
            else if (mem_en) core_issues++;
        end
        check({tag, ".dma_granted"}, 32'(got), 32'd1);
        check({tag, ".core_wins_before_dma"}, 32'(core_issues), 32'd3);
        check({tag, ".dma_mem_we"}, 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        dma_req = 1'b0;
        @(negedge clk);
        check({tag, ".rvalid"}, 32'(dma_rvalid), 32'd1);
        check({tag, ".dma_rdata"}, dma_rdata, exp_dma);
        cycles = 0;
        while (!core_done && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ".core_resume"}, 32'(core_done), 32'd1);
        check({tag, ".core_resume_rdata"}, core_rdata, exp_core);
        @(posedge clk); #1;
        core_rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] w;
        logic [31:0] a;
        logic        rd, wr;
        logic [2:0]  f3;
        int          kind, pick;

        rst = 1'b1;
        core_rd_en = 1'b0; core_wr_en = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;

        // Preload memory and reference model while reset is held.
        for (int i = 0; i < 256; i++) begin
            w = (i == 8) ? 32'h80FF_7F01 : $urandom;
            @(negedge clk);
            pre_we = 1'b1; pre_idx = 8'(i); pre_val = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        check("reset.core_done",  32'(core_done),  32'd0);
        check("reset.core_fault", 32'(core_fault), 32'd0);
        check("reset.core_rdata", core_rdata,      32'd0);
        check("reset.dma_gnt",    32'(dma_gnt),    32'd0);
        check("reset.dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("reset.dma_rdata",  dma_rdata,       32'd0);
        check("reset.mem_en",     32'(mem_en),     32'd0);
        check("reset.core_stall", 32'(core_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word store then load back.
        core_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "SW10", obs);
        core_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "LW10", obs);
        check("LW10.const", obs, 32'hDEAD_BEEF);

        // Sub-word loads with sign and zero extension.
        core_access(1'b1, 1'b0, 3'b000, 32'h23, 32'h0, "LB23", obs);
        check("LB23.const", obs, 32'hFFFF_FF80);
        core_access(1'b1, 1'b0, 3'b100, 32'h23, 32'h0, "LBU23", obs);
        check("LBU23.const", obs, 32'h0000_0080);
        core_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, "LH22", obs);
        check("LH22.const", obs, 32'hFFFF_80FF);
        core_access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, "LHU20", obs);
        check("LHU20.const", obs, 32'h0000_7F01);

        // Sub-word stores, then read the merged word.
        core_access(1'b0, 1'b1, 3'b000, 32'h31, 32'h0000_00AB, "SB31", obs);
        core_access(1'b0, 1'b1, 3'b001, 32'h32, 32'h0000_1234, "SH32", obs);
        core_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, "LW30", obs);

        // Faults.
        core_access(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, "LW42_fault", obs);
        core_access(1'b0, 1'b1, 3'b001, 32'h41, 32'h5555, "SH41_fault", obs);
        core_access(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, "F3_011_fault", obs);
        core_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h0, "RDWR_fault", obs);

        // Uncontended DMA traffic, with a core read-back of the DMA write.
        dma_access(1'b1, 32'h100, 32'h1234_5678, "DMAW100");
        core_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "LW100", obs);
        check("LW100.const", obs, 32'h1234_5678);
        dma_access(1'b0, 32'h23, 32'h0, "DMAR20");

        // Starvation guard, twice to show the counter clears on the DMA grant.
        starve_run(32'h10, 32'h200, "STARVE1");
        starve_run(32'h20, 32'h204, "STARVE2");

        // Random core traffic, mostly legal, some arbitrary.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = $urandom_range(0, 1020);
            if (kind < 8) begin
                rd = 1'($urandom_range(0, 1));
                wr = !rd;
                pick = int'($urandom_range(0, rd ? 4 : 2));
                f3 = 3'((pick > 2) ? pick + 1 : pick);
                a  = a & ~((32'd1 << f3[1:0]) - 32'd1);
            end else begin
                rd = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                if (!rd && !wr) rd = 1'b1;
                f3 = 3'($urandom_range(0, 7));
            end
            core_access(rd, wr, f3, a, $urandom, "RAND", obs);
        end

        // Reset in the CORE_RD cycle of a load.
        @(posedge clk); #1;
        core_rd_en = 1'b1; core_wr_en = 1'b0; core_funct3 = 3'b010; core_addr = 32'h10;
        @(negedge clk);
        check("RSTMID.issue_mem_en", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; core_rd_en = 1'b0;
        @(negedge clk);
        check("RSTMID.mem_en_in_reset", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("RSTMID.core_done",  32'(core_done),  32'd0);
        check("RSTMID.core_fault", 32'(core_fault), 32'd0);
        check("RSTMID.core_rdata", core_rdata,      32'd0);
        check("RSTMID.dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("RSTMID.dma_gnt",    32'(dma_gnt),    32'd0);
        check("RSTMID.mem_en",     32'(mem_en),     32'd0);
        check("RSTMID.core_stall", 32'(core_stall), 32'd0);
        core_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "LW_after_rst", obs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit in case a DUT handshake never arrives.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
